// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop input sync, oversampled bit timing with a 3-sample
// majority vote, 5..9 data bits, optional parity, 1..2 stop bits, and a
// valid/ready holding register with per-word status and an overrun pulse.
module uart_rx_param #(
  parameter int CLK_HZ      = 25000000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_HZ / (BAUD_RATE * SAMPLE_RATE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW      = $clog2(SAMPLE_RATE);

  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [KW-1:0] K_S0   = KW'(SAMPLE_RATE / 2 - 1);
  localparam logic [KW-1:0] K_S1   = KW'(SAMPLE_RATE / 2);
  localparam logic [KW-1:0] K_DEC  = KW'(SAMPLE_RATE / 2 + 1);
  localparam logic [KW-1:0] K_END  = KW'(SAMPLE_RATE - 1);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } word_t;

  state_t               state, state_nxt;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [KW-1:0]        k;
  logic                 tick, dec, bit_end;
  logic                 s0, s1, maj;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bcnt;
  logic                 perr, ferr;
  logic                 done;
  word_t                hold;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end

  // Oversample tick divider and in-bit tick index; parked at zero while idle
  // so every frame starts its timing from the detected start edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      k   <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
      k   <= '0;
    end else if (tick) begin
      cnt <= '0;
      k   <= (k == K_END) ? '0 : k + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick    = (cnt == C_LAST);
  assign dec     = tick && (k == K_DEC);
  assign bit_end = tick && (k == K_END);
  assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  // Capture the two early samples; the third is rx_s at the decision tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (tick) begin
      if (k == K_S0) s0 <= rx_s;
      if (k == K_S1) s1 <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; frame completes at the last stop-bit decision (mid-bit)
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE:   if (!rx_s) state_nxt = S_START;
      S_START: begin
        if (dec && maj)   state_nxt = S_IDLE;
        else if (bit_end) state_nxt = S_DATA;
      end
      S_DATA:   if (bit_end && bcnt == D_LAST)
                  state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        if (dec && bcnt == S_LAST) begin
          done      = 1'b1;
          state_nxt = (ferr || !maj) ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath: LSB-first shift, bit counter, per-frame error flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      bcnt  <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bcnt <= '0;
          perr <= 1'b0;
          ferr <= 1'b0;
        end
        S_DATA: begin
          if (dec)     shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (bit_end) bcnt  <= (bcnt == D_LAST) ? '0 : bcnt + 1'b1;
        end
        S_PARITY: begin
          // odd: data^parity must be 1, even: must be 0
          if (dec) perr <= (^shreg) ^ maj ^ (PARITY_MODE == 1);
        end
        S_STOP: begin
          if (dec && !maj) ferr <= 1'b1;
          if (bit_end)     bcnt <= bcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Holding register: load on completion if empty or being drained this
  // cycle, otherwise drop the word and pulse overrun
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold     <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          hold     <= '{data: shreg, perr: perr, ferr: ferr | !maj};
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = hold.data;
  assign rx_parity_err = hold.perr;
  assign rx_frame_err  = hold.ferr;
  assign busy          = (state != S_IDLE);

endmodule
